// File: rtl/issue_queue_pkg.sv
// Shared types and default widths for the issue queue slice.
// Holds the FU class encodings and the default-width entry layout.
package issue_queue_pkg;

    localparam int DEF_PREG_W  = 6;
    localparam int DEF_ROB_W   = 4;
    localparam int DEF_ALUOP_W = 4;
    localparam int DEF_FU_W    = 2;

    typedef enum logic [DEF_FU_W-1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_LSU = 2'd2,
        FU_BR  = 2'd3
    } fu_class_e;

    typedef struct packed {
        logic                   valid;
        logic                   rdy1;
        logic                   rdy2;
        logic [DEF_PREG_W-1:0]  sr1_p;
        logic [DEF_PREG_W-1:0]  sr2_p;
        logic [DEF_PREG_W-1:0]  dr_p;
        logic [DEF_ALUOP_W-1:0] aluOp;
        logic [31:0]            imm;
        logic [DEF_FU_W-1:0]    FU;
        logic [DEF_ROB_W-1:0]   ROB_num;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_prio_enc.sv
// Lowest-index priority encoder: one-hot grant plus binary index of the winner.
// Both outputs are zero when no request bit is set.
module prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Reservation station after rename: holds instructions until both sources are
// ready (rename bits or writeback broadcasts), then issues lowest-index first.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int PREG_W  = DEF_PREG_W,
    parameter int ROB_W   = DEF_ROB_W,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int FU_W    = DEF_FU_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [PREG_W-1:0]  disp_sr1_p,
    input  logic [PREG_W-1:0]  disp_sr2_p,
    input  logic [PREG_W-1:0]  disp_dr_p,
    input  logic               disp_s1_ready,
    input  logic               disp_s2_ready,
    input  logic [ALUOP_W-1:0] disp_aluOp,
    input  logic [31:0]        disp_imm,
    input  logic [FU_W-1:0]    disp_FU,
    input  logic [ROB_W-1:0]   disp_ROB_num,
    input  logic [1:0]         wb_valid,
    input  logic [PREG_W-1:0]  wb_tag0,
    input  logic [PREG_W-1:0]  wb_tag1,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [PREG_W-1:0]  iss_sr1_p,
    output logic [PREG_W-1:0]  iss_sr2_p,
    output logic [PREG_W-1:0]  iss_dr_p,
    output logic [ALUOP_W-1:0] iss_aluOp,
    output logic [31:0]        iss_imm,
    output logic [FU_W-1:0]    iss_FU,
    output logic [ROB_W-1:0]   iss_ROB_num
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic               valid;
        logic               rdy1;
        logic               rdy2;
        logic [PREG_W-1:0]  sr1_p;
        logic [PREG_W-1:0]  sr2_p;
        logic [PREG_W-1:0]  dr_p;
        logic [ALUOP_W-1:0] aluOp;
        logic [31:0]        imm;
        logic [FU_W-1:0]    FU;
        logic [ROB_W-1:0]   ROB_num;
    } entry_t;

    entry_t             entry_q [DEPTH];
    entry_t             entry_d [DEPTH];
    entry_t             newEntry;
    logic [DEPTH-1:0]   freeVec;
    logic [DEPTH-1:0]   eligVec;
    logic [DEPTH-1:0]   freeOneHot;
    logic [DEPTH-1:0]   selOneHot;
    logic [IDX_W-1:0]   freeIdx;
    logic [IDX_W-1:0]   selIdx;
    logic               dispFire;
    logic               issFire;

    function automatic logic wbHit(input logic [PREG_W-1:0] tag, input logic [1:0] wbv,
                                   input logic [PREG_W-1:0] t0, input logic [PREG_W-1:0] t1);
        return (wbv[0] && (tag == t0)) || (wbv[1] && (tag == t1));
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            freeVec[i] = ~entry_q[i].valid;
            eligVec[i] = entry_q[i].valid & entry_q[i].rdy1 & entry_q[i].rdy2;
        end
    end

    prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_freeEnc (
        .req_i    (freeVec),
        .onehot_o (freeOneHot),
        .idx_o    (freeIdx)
    );

    prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_selEnc (
        .req_i    (eligVec),
        .onehot_o (selOneHot),
        .idx_o    (selIdx)
    );

    assign disp_ready = |freeOneHot;
    assign iss_valid  = |selOneHot;
    assign dispFire   = disp_valid && disp_ready;
    assign issFire    = iss_valid && iss_ready;

    // Incoming instruction sees the same broadcast as stored entries; tag 0 is always ready.
    always_comb begin
        newEntry         = '0;
        newEntry.valid   = 1'b1;
        newEntry.rdy1    = disp_s1_ready || (disp_sr1_p == '0) ||
                           wbHit(disp_sr1_p, wb_valid, wb_tag0, wb_tag1);
        newEntry.rdy2    = disp_s2_ready || (disp_sr2_p == '0) ||
                           wbHit(disp_sr2_p, wb_valid, wb_tag0, wb_tag1);
        newEntry.sr1_p   = disp_sr1_p;
        newEntry.sr2_p   = disp_sr2_p;
        newEntry.dr_p    = disp_dr_p;
        newEntry.aluOp   = disp_aluOp;
        newEntry.imm     = disp_imm;
        newEntry.FU      = disp_FU;
        newEntry.ROB_num = disp_ROB_num;
    end

    // Flush is applied last so it overrides wakeup, issue and dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].valid) begin
                if (wbHit(entry_q[i].sr1_p, wb_valid, wb_tag0, wb_tag1)) entry_d[i].rdy1 = 1'b1;
                if (wbHit(entry_q[i].sr2_p, wb_valid, wb_tag0, wb_tag1)) entry_d[i].rdy2 = 1'b1;
            end
        end
        if (issFire) entry_d[selIdx].valid = 1'b0;
        if (dispFire) entry_d[freeIdx] = newEntry;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) entry_d[i].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
        end
    end

    assign iss_sr1_p   = iss_valid ? entry_q[selIdx].sr1_p   : '0;
    assign iss_sr2_p   = iss_valid ? entry_q[selIdx].sr2_p   : '0;
    assign iss_dr_p    = iss_valid ? entry_q[selIdx].dr_p    : '0;
    assign iss_aluOp   = iss_valid ? entry_q[selIdx].aluOp   : '0;
    assign iss_imm     = iss_valid ? entry_q[selIdx].imm     : '0;
    assign iss_FU      = iss_valid ? entry_q[selIdx].FU      : '0;
    assign iss_ROB_num = iss_valid ? entry_q[selIdx].ROB_num : '0;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: expected issues are queued at dispatch time
// and compared field by field when the queue presents them.
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [5:0]  disp_sr1_p = '0, disp_sr2_p = '0, disp_dr_p = '0;
    logic        disp_s1_ready = 1'b0, disp_s2_ready = 1'b0;
    logic [3:0]  disp_aluOp = '0;
    logic [31:0] disp_imm = '0;
    logic [1:0]  disp_FU = '0;
    logic [3:0]  disp_ROB_num = '0;
    logic [1:0]  wb_valid = '0;
    logic [5:0]  wb_tag0 = '0, wb_tag1 = '0;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [5:0]  iss_sr1_p, iss_sr2_p, iss_dr_p;
    logic [3:0]  iss_aluOp;
    logic [31:0] iss_imm;
    logic [1:0]  iss_FU;
    logic [3:0]  iss_ROB_num;

    int          checks = 0;
    int          failures = 0;
    iq_entry_t   sbQ[$];

    always #5 clk = ~clk;

    issue_queue dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_sr1_p    (disp_sr1_p),
        .disp_sr2_p    (disp_sr2_p),
        .disp_dr_p     (disp_dr_p),
        .disp_s1_ready (disp_s1_ready),
        .disp_s2_ready (disp_s2_ready),
        .disp_aluOp    (disp_aluOp),
        .disp_imm      (disp_imm),
        .disp_FU       (disp_FU),
        .disp_ROB_num  (disp_ROB_num),
        .wb_valid      (wb_valid),
        .wb_tag0       (wb_tag0),
        .wb_tag1       (wb_tag1),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_sr1_p     (iss_sr1_p),
        .iss_sr2_p     (iss_sr2_p),
        .iss_dr_p      (iss_dr_p),
        .iss_aluOp     (iss_aluOp),
        .iss_imm       (iss_imm),
        .iss_FU        (iss_FU),
        .iss_ROB_num   (iss_ROB_num)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Payload fields other than tags are derived from dr/rob so every entry is distinct.
    task automatic applyStimulus(input logic [5:0] sr1, input logic [5:0] sr2, input logic [5:0] dr,
                                 input logic s1r, input logic s2r, input logic [3:0] rob,
                                 input bit push);
        iq_entry_t e;
        disp_valid    = 1'b1;
        disp_sr1_p    = sr1;
        disp_sr2_p    = sr2;
        disp_dr_p     = dr;
        disp_s1_ready = s1r;
        disp_s2_ready = s2r;
        disp_aluOp    = rob ^ 4'h5;
        disp_imm      = 32'hA5000000 | {26'd0, dr};
        disp_FU       = rob[1:0];
        disp_ROB_num  = rob;
        if (push) begin
            e         = '0;
            e.valid   = 1'b1;
            e.sr1_p   = sr1;
            e.sr2_p   = sr2;
            e.dr_p    = dr;
            e.aluOp   = rob ^ 4'h5;
            e.imm     = 32'hA5000000 | {26'd0, dr};
            e.FU      = rob[1:0];
            e.ROB_num = rob;
            sbQ.push_back(e);
        end
    endtask

    task automatic checkIssue(input string tag);
        iq_entry_t e;
        checkOutput({tag, "_sb_nonempty"}, 64'(sbQ.size() != 0), 64'd1);
        checkOutput({tag, "_valid"}, 64'(iss_valid), 64'd1);
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput({tag, "_dr"}, 64'(iss_dr_p), 64'(e.dr_p));
            checkOutput({tag, "_rob"}, 64'(iss_ROB_num), 64'(e.ROB_num));
            checkOutput({tag, "_imm"}, 64'(iss_imm), 64'(e.imm));
            checkOutput({tag, "_misc"}, 64'({iss_sr1_p, iss_sr2_p, iss_aluOp, iss_FU}),
                        64'({e.sr1_p, e.sr2_p, e.aluOp, e.FU}));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2;
        checkOutput("rst_disp_ready", 64'(disp_ready), 64'd1);
        checkOutput("rst_iss_valid", 64'(iss_valid), 64'd0);
        checkOutput("rst_iss_dr", 64'(iss_dr_p), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ready instruction issues one cycle after dispatch.
        iss_ready = 1'b1;
        applyStimulus(6'd5, 6'd6, 6'd10, 1'b1, 1'b1, 4'd3, 1'b1);
        sample();
        checkOutput("t1_pre_iss_valid", 64'(iss_valid), 64'd0);
        tick();
        disp_valid = 1'b0;
        sample();
        checkIssue("t1_issue");
        tick();
        sample();
        checkOutput("t1_freed_iss_valid", 64'(iss_valid), 64'd0);
        checkOutput("t1_freed_disp_ready", 64'(disp_ready), 64'd1);
        tick();

        // Source 1 waits on a port-0 broadcast; source 2 is tag 0.
        applyStimulus(6'd7, 6'd0, 6'd11, 1'b0, 1'b0, 4'd4, 1'b1);
        sample();
        checkOutput("t2_pre_iss_valid", 64'(iss_valid), 64'd0);
        tick();
        disp_valid = 1'b0;
        sample();
        checkOutput("t2_wait_iss_valid", 64'(iss_valid), 64'd0);
        tick();
        wb_valid = 2'b01;
        wb_tag0  = 6'd7;
        sample();
        checkOutput("t2_no_comb_path", 64'(iss_valid), 64'd0);
        tick();
        wb_valid = 2'b00;
        sample();
        checkIssue("t2_issue");
        tick();
        sample();
        checkOutput("t2_after_iss_valid", 64'(iss_valid), 64'd0);
        tick();

        // Dispatch coincides with its producer's port-1 broadcast.
        applyStimulus(6'd9, 6'd3, 6'd12, 1'b0, 1'b1, 4'd5, 1'b1);
        wb_valid = 2'b10;
        wb_tag1  = 6'd9;
        sample();
        checkOutput("t3_pre_iss_valid", 64'(iss_valid), 64'd0);
        tick();
        disp_valid = 1'b0;
        wb_valid   = 2'b00;
        sample();
        checkIssue("t3_issue");
        tick();
        sample();
        checkOutput("t3_after_iss_valid", 64'(iss_valid), 64'd0);
        tick();

        // Fill all eight slots while execute stalls, then drain in index order.
        iss_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(6'(i + 1), 6'(i + 2), 6'(20 + i), 1'b1, 1'b1, 4'(i), 1'b1);
            sample();
            checkOutput($sformatf("t4_fill%0d_disp_ready", i), 64'(disp_ready), 64'd1);
            tick();
        end
        applyStimulus(6'd1, 6'd2, 6'd40, 1'b1, 1'b1, 4'd15, 1'b0);
        sample();
        checkOutput("t4_full_disp_ready", 64'(disp_ready), 64'd0);
        checkOutput("t4_stall_iss_valid", 64'(iss_valid), 64'd1);
        checkOutput("t4_stall_iss_dr", 64'(iss_dr_p), 64'd20);
        tick();
        disp_valid = 1'b0;
        iss_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (i == 0) checkOutput("t4_full_during_issue", 64'(disp_ready), 64'd0);
            if (i == 1) checkOutput("t4_disp_ready_back", 64'(disp_ready), 64'd1);
            checkIssue($sformatf("t4_drain%0d", i));
            tick();
        end
        sample();
        checkOutput("t4_ninth_ignored", 64'(iss_valid), 64'd0);
        checkOutput("t4_empty_disp_ready", 64'(disp_ready), 64'd1);
        tick();

        // Flush with four valid entries and a concurrent dispatch.
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'd1, 6'd2, 6'(50 + i), 1'b1, 1'b1, 4'(i), 1'b0);
            tick();
        end
        applyStimulus(6'd1, 6'd2, 6'd60, 1'b1, 1'b1, 4'd9, 1'b0);
        flush = 1'b1;
        sample();
        checkOutput("t5_pre_flush_iss_valid", 64'(iss_valid), 64'd1);
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        iss_ready  = 1'b1;
        sample();
        checkOutput("t5_flush_iss_valid", 64'(iss_valid), 64'd0);
        checkOutput("t5_flush_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        sample();
        checkOutput("t5_disp_not_stored", 64'(iss_valid), 64'd0);
        tick();

        // Asynchronous reset between edges clears everything immediately.
        iss_ready = 1'b0;
        applyStimulus(6'd1, 6'd2, 6'd33, 1'b1, 1'b1, 4'd1, 1'b0);
        tick();
        applyStimulus(6'd3, 6'd4, 6'd34, 1'b1, 1'b1, 4'd2, 1'b0);
        tick();
        disp_valid = 1'b0;
        sample();
        checkOutput("t6_pre_rst_iss_valid", 64'(iss_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_iss_valid", 64'(iss_valid), 64'd0);
        checkOutput("t6_async_disp_ready", 64'(disp_ready), 64'd1);
        checkOutput("t6_async_iss_dr", 64'(iss_dr_p), 64'd0);
        tick();
        rst = 1'b0;
        sample();
        checkOutput("t6_post_rst_iss_valid", 64'(iss_valid), 64'd0);

        checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
